// File: rtl/perf_monitor_if.sv
// Bus between an RV32I core tap and perf_monitor: control, trace inputs and counter read port.
// master = core/debug side driving the taps, slave = the monitor itself.
interface perf_monitor_if #(
    parameter int CNT_W   = 32,
    parameter int NUM_EVT = 4
) ();
    localparam int SEL_W = $clog2(NUM_EVT + 3);

    logic                 i_en;
    logic                 i_clr;
    logic                 i_insn_vld;
    logic [31:0]          i_instr;
    logic [NUM_EVT-1:0]   i_evt;
    logic [SEL_W-1:0]     i_rd_sel;
    logic [CNT_W-1:0]     o_rd_data;
    logic [NUM_EVT+2:0]   o_ovf;
    logic [1:0]           o_state;
    logic                 o_halted;

    modport master (
        output i_en, i_clr, i_insn_vld, i_instr, i_evt, i_rd_sel,
        input  o_rd_data, o_ovf, o_state, o_halted
    );

    modport slave (
        input  i_en, i_clr, i_insn_vld, i_instr, i_evt, i_rd_sel,
        output o_rd_data, o_ovf, o_state, o_halted
    );
endinterface

// File: rtl/perf_monitor.sv
// Pipeline performance monitor: cycle/valid/bubble/event counters with halt-triggered freeze.
// Define PERF_MON_SAT_EN to make counters saturate instead of wrapping.
module perf_monitor #(
    parameter int          CNT_W     = 32,
    parameter int          NUM_EVT   = 4,
    parameter logic [31:0] HALT_INSN = 32'h0000006f,
    parameter int          HALT_HOLD = 4
) (
    input  logic           i_clk,
    input  logic           i_rstn,
    perf_monitor_if.slave  bus
);
    localparam int NUM_CNT = NUM_EVT + 3;
    localparam int HOLD_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    state_t                     state_reg;
    logic                       halted_reg;
    logic [HOLD_W-1:0]          hold_reg;
    logic [CNT_W-1:0]           rd_data_reg;
    logic [CNT_W-1:0]           rd_data_next;
    logic [NUM_CNT*CNT_W-1:0]   cnt_flat;
    logic [NUM_CNT-1:0]         ovf_flat;
    logic [NUM_CNT-1:0]         inc;
    logic                       count_en;

    // The hold countdown keeps running while paused; only counters honour i_en.
    assign count_en = bus.i_en && ((state_reg == ST_RUN) || (state_reg == ST_DRAIN));

    assign inc[0] = 1'b1;
    assign inc[1] = bus.i_insn_vld;
    assign inc[2] = ~bus.i_insn_vld;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_EVT; gi++) begin : g_evt
            assign inc[3 + gi] = bus.i_evt[gi];
        end

        for (gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_reg;
            logic             ovf_reg;
            logic             at_max;

            assign at_max = &cnt_reg;

            always_ff @(posedge i_clk or negedge i_rstn) begin
                if (!i_rstn) begin
                    cnt_reg <= '0;
                    ovf_reg <= 1'b0;
                end else if (bus.i_clr) begin
                    cnt_reg <= '0;
                    ovf_reg <= 1'b0;
                end else if (count_en && inc[gi]) begin
                    if (at_max) begin
                        ovf_reg <= 1'b1;
`ifdef PERF_MON_SAT_EN
                        cnt_reg <= cnt_reg;
`else
                        cnt_reg <= '0;
`endif
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
            end

            assign cnt_flat[gi*CNT_W +: CNT_W] = cnt_reg;
            assign ovf_flat[gi]                = ovf_reg;
        end
    endgenerate

    // Hold counter starts at HALT_HOLD-1 so DRAIN lasts exactly HALT_HOLD edges.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_reg  <= ST_IDLE;
            hold_reg   <= '0;
            halted_reg <= 1'b0;
        end else if (bus.i_clr) begin
            state_reg  <= ST_IDLE;
            hold_reg   <= '0;
            halted_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (bus.i_en) state_reg <= ST_RUN;
                end
                ST_RUN: begin
                    if (bus.i_instr == HALT_INSN) begin
                        state_reg <= ST_DRAIN;
                        hold_reg  <= HOLD_W'(HALT_HOLD - 1);
                    end
                end
                ST_DRAIN: begin
                    if (hold_reg == '0) begin
                        state_reg  <= ST_HALTED;
                        halted_reg <= 1'b1;
                    end else begin
                        hold_reg <= hold_reg - HOLD_W'(1);
                    end
                end
                default: begin
                    state_reg <= ST_HALTED;
                end
            endcase
        end
    end

    // Out-of-range selects read as zero.
    always_comb begin
        rd_data_next = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            if (int'(bus.i_rd_sel) == i) rd_data_next = cnt_flat[i*CNT_W +: CNT_W];
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) rd_data_reg <= '0;
        else         rd_data_reg <= rd_data_next;
    end

    assign bus.o_rd_data = rd_data_reg;
    assign bus.o_ovf     = ovf_flat;
    assign bus.o_state   = state_reg;
    assign bus.o_halted  = halted_reg;
endmodule

// File: tb/tb_perf_monitor.sv
// Randomized self-checking bench for perf_monitor against a rule-level reference model.
module tb_perf_monitor;
    localparam int CNT_W     = 32;
    localparam int NUM_EVT   = 4;
    localparam int HALT_HOLD = 4;
    localparam int NC        = NUM_EVT + 3;
    localparam int SEL_W     = $clog2(NC);
    localparam logic [31:0] HALT = 32'h0000006f;
    localparam logic [31:0] NOP  = 32'h00000013;
    localparam longint unsigned MAXV = (longint'(1) << CNT_W) - 1;
`ifdef PERF_MON_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    perf_monitor_if #(.CNT_W(CNT_W), .NUM_EVT(NUM_EVT)) bus ();
    perf_monitor_if #(.CNT_W(4),     .NUM_EVT(NUM_EVT)) sbus ();

    perf_monitor #(.CNT_W(CNT_W), .NUM_EVT(NUM_EVT), .HALT_INSN(HALT), .HALT_HOLD(HALT_HOLD))
        dut (.i_clk(clk), .i_rstn(rst_n), .bus(bus));
    perf_monitor #(.CNT_W(4), .NUM_EVT(NUM_EVT), .HALT_INSN(HALT), .HALT_HOLD(HALT_HOLD))
        dut_s (.i_clk(clk), .i_rstn(rst_n), .bus(sbus));

    // Reference model: state as 0..3, drain tracked as remaining edges.
    longint unsigned m_cnt [NC];
    logic [NC-1:0]   m_ovf;
    int              m_st;
    int              m_left;
    longint unsigned m_rd;

    task automatic model_reset();
        for (int i = 0; i < NC; i++) m_cnt[i] = 0;
        m_ovf = '0; m_st = 0; m_left = 0; m_rd = 0;
    endtask

    task automatic model_step();
        bit hit;
        m_rd = (int'(bus.i_rd_sel) < NC) ? m_cnt[bus.i_rd_sel] : 0;
        if (bus.i_clr) begin
            for (int i = 0; i < NC; i++) m_cnt[i] = 0;
            m_ovf = '0; m_st = 0; m_left = 0;
        end else begin
            if (bus.i_en && (m_st == 1 || m_st == 2)) begin
                for (int i = 0; i < NC; i++) begin
                    if (i == 0)      hit = 1'b1;
                    else if (i == 1) hit = bus.i_insn_vld;
                    else if (i == 2) hit = !bus.i_insn_vld;
                    else             hit = bus.i_evt[i-3];
                    if (hit) begin
                        if (m_cnt[i] == MAXV) begin
                            m_ovf[i] = 1'b1;
                            m_cnt[i] = SAT ? MAXV : 0;
                        end else m_cnt[i] = m_cnt[i] + 1;
                    end
                end
            end
            if (m_st == 0) begin
                if (bus.i_en) m_st = 1;
            end else if (m_st == 1) begin
                if (bus.i_instr == HALT) begin m_st = 2; m_left = HALT_HOLD; end
            end else if (m_st == 2) begin
                m_left = m_left - 1;
                if (m_left == 0) m_st = 3;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        bus.i_en = 0; bus.i_clr = 0; bus.i_insn_vld = 0; bus.i_instr = NOP;
        bus.i_evt = '0; bus.i_rd_sel = '0;
        sbus.i_en = 0; sbus.i_clr = 0; sbus.i_insn_vld = 0; sbus.i_instr = NOP;
        sbus.i_evt = '0; sbus.i_rd_sel = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.o_state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", bus.o_state); end
        checks++; if (bus.o_halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%0b exp=0", bus.o_halted); end
        checks++; if (bus.o_rd_data !== '0) begin failures++; $display("FAIL reset_rd got=%0h exp=0", bus.o_rd_data); end
        checks++; if (bus.o_ovf !== '0) begin failures++; $display("FAIL reset_ovf got=%0h exp=0", bus.o_ovf); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_count_basic();
        int pat [5] = '{1, 1, 0, 1, 0};
        longint unsigned exp3 [3] = '{5, 3, 2};
        bus.i_clr = 1; tick(); bus.i_clr = 0;
        bus.i_en = 1; bus.i_insn_vld = 0; bus.i_instr = NOP; tick();
        for (int i = 0; i < 5; i++) begin
            bus.i_insn_vld = pat[i][0];
            tick();
        end
        bus.i_en = 0;
        for (int s = 0; s < 3; s++) begin
            bus.i_rd_sel = SEL_W'(s); tick();
            checks++; if (bus.o_rd_data !== CNT_W'(exp3[s])) begin failures++; $display("FAIL basic_cnt sel=%0d got=%0d exp=%0d", s, bus.o_rd_data, exp3[s]); end
        end
        bus.i_clr = 1; tick(); bus.i_clr = 0;
        for (int s = 0; s < 3; s++) begin
            bus.i_rd_sel = SEL_W'(s); tick();
            checks++; if (bus.o_rd_data !== '0) begin failures++; $display("FAIL basic_clr sel=%0d got=%0d exp=0", s, bus.o_rd_data); end
        end
        checks++; if (bus.o_state !== 2'd0) begin failures++; $display("FAIL basic_clr_state got=%0d exp=0", bus.o_state); end
    endtask

    task automatic test_halt();
        bus.i_clr = 1; tick(); bus.i_clr = 0;
        bus.i_en = 1; bus.i_instr = NOP; bus.i_rd_sel = '0; tick();
        repeat (10) begin
            bus.i_insn_vld = 1'($urandom); bus.i_evt = NUM_EVT'($urandom); tick();
        end
        bus.i_instr = HALT; tick(); bus.i_instr = NOP;
        checks++; if (bus.o_state !== 2'd2) begin failures++; $display("FAIL halt_drain0 got=%0d exp=2", bus.o_state); end
        for (int i = 1; i < 4; i++) begin
            tick();
            checks++; if (bus.o_state !== 2'd2) begin failures++; $display("FAIL halt_drain%0d got=%0d exp=2", i, bus.o_state); end
        end
        tick();
        checks++; if (bus.o_state !== 2'd3) begin failures++; $display("FAIL halt_state got=%0d exp=3", bus.o_state); end
        checks++; if (bus.o_halted !== 1'b1) begin failures++; $display("FAIL halt_flag got=%0b exp=1", bus.o_halted); end
        for (int i = 0; i < 20; i++) begin
            bus.i_insn_vld = 1'($urandom); bus.i_evt = NUM_EVT'($urandom);
            bus.i_instr = (i == 5) ? HALT : NOP;
            tick();
            checks++; if (bus.o_rd_data !== CNT_W'(15)) begin failures++; $display("FAIL halt_frozen i=%0d got=%0d exp=15", i, bus.o_rd_data); end
        end
        checks++; if (bus.o_state !== 2'd3) begin failures++; $display("FAIL halt_hold got=%0d exp=3", bus.o_state); end
    endtask

    task automatic test_pause_and_latency();
        int ens [4] = '{1, 0, 0, 1};
        bus.i_clr = 1; tick(); bus.i_clr = 0;
        bus.i_en = 1; bus.i_insn_vld = 0; bus.i_evt = '0; bus.i_instr = NOP; tick();
        for (int i = 0; i < 4; i++) begin
            bus.i_en = ens[i][0]; tick();
        end
        bus.i_en = 0; bus.i_rd_sel = 0; tick();
        checks++; if (bus.o_rd_data !== CNT_W'(2)) begin failures++; $display("FAIL pause_cycles got=%0d exp=2", bus.o_rd_data); end
        bus.i_rd_sel = 1; #1;
        checks++; if (bus.o_rd_data !== CNT_W'(2)) begin failures++; $display("FAIL lat_before got=%0d exp=2", bus.o_rd_data); end
        tick();
        checks++; if (bus.o_rd_data !== '0) begin failures++; $display("FAIL lat_after got=%0d exp=0", bus.o_rd_data); end
        bus.i_rd_sel = 2; tick();
        checks++; if (bus.o_rd_data !== CNT_W'(2)) begin failures++; $display("FAIL pause_bubbles got=%0d exp=2", bus.o_rd_data); end
        bus.i_rd_sel = SEL_W'(NC); tick();
        checks++; if (bus.o_rd_data !== '0) begin failures++; $display("FAIL bad_sel got=%0d exp=0", bus.o_rd_data); end
    endtask

    task automatic test_async_reset();
        bus.i_clr = 1; tick(); bus.i_clr = 0;
        bus.i_en = 1; bus.i_rd_sel = 0; bus.i_instr = NOP; tick();
        repeat (3) tick();
        bus.i_instr = HALT; tick(); bus.i_instr = NOP; tick();
        checks++; if (bus.o_state !== 2'd2) begin failures++; $display("FAIL arst_pre_drain got=%0d exp=2", bus.o_state); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (bus.o_state !== 2'd0) begin failures++; $display("FAIL arst_state got=%0d exp=0", bus.o_state); end
        checks++; if (bus.o_rd_data !== '0) begin failures++; $display("FAIL arst_rd got=%0d exp=0", bus.o_rd_data); end
        checks++; if (bus.o_halted !== 1'b0 || bus.o_ovf !== '0) begin failures++; $display("FAIL arst_flags halted=%0b ovf=%0h exp=0", bus.o_halted, bus.o_ovf); end
        model_reset();
        bus.i_en = 0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++; if (bus.o_state !== 2'd0) begin failures++; $display("FAIL arst_release got=%0d exp=0", bus.o_state); end
    endtask

    task automatic test_clr_halt();
        bus.i_clr = 1; tick(); bus.i_clr = 0;
        bus.i_en = 0; bus.i_instr = HALT; tick();
        checks++; if (bus.o_state !== 2'd0) begin failures++; $display("FAIL idle_ignores_halt got=%0d exp=0", bus.o_state); end
        bus.i_en = 1; bus.i_instr = NOP; tick();
        repeat (3) tick();
        bus.i_instr = HALT; bus.i_clr = 1; tick();
        bus.i_instr = NOP; bus.i_clr = 0; bus.i_en = 0;
        checks++; if (bus.o_state !== 2'd0) begin failures++; $display("FAIL clr_halt_state got=%0d exp=0", bus.o_state); end
        bus.i_rd_sel = 0; tick();
        checks++; if (bus.o_rd_data !== '0) begin failures++; $display("FAIL clr_halt_cnt got=%0d exp=0", bus.o_rd_data); end
        checks++; if (bus.o_state !== 2'd0) begin failures++; $display("FAIL clr_halt_no_drain got=%0d exp=0", bus.o_state); end
    endtask

    task automatic test_overflow();
        logic [3:0] exp_v;
        exp_v = SAT ? 4'd15 : 4'd1;
        sbus.i_clr = 1; tick(); sbus.i_clr = 0;
        sbus.i_en = 1; sbus.i_insn_vld = 0; sbus.i_evt = '0; tick();
        sbus.i_evt = 4'b0001;
        repeat (17) tick();
        sbus.i_en = 0; sbus.i_evt = '0; sbus.i_rd_sel = 3; tick();
        checks++; if (sbus.o_rd_data !== exp_v) begin failures++; $display("FAIL ovf_evt0 got=%0d exp=%0d", sbus.o_rd_data, exp_v); end
        checks++; if (sbus.o_ovf !== 7'b0001101) begin failures++; $display("FAIL ovf_flags got=%b exp=0001101", sbus.o_ovf); end
        sbus.i_rd_sel = 0; tick();
        checks++; if (sbus.o_rd_data !== exp_v) begin failures++; $display("FAIL ovf_cycles got=%0d exp=%0d", sbus.o_rd_data, exp_v); end
        // Bring evt0 to 15, then clear on the edge that would overflow it.
        sbus.i_clr = 1; tick(); sbus.i_clr = 0;
        sbus.i_en = 1; tick();
        sbus.i_evt = 4'b0001;
        repeat (15) tick();
        checks++; if (sbus.o_ovf !== '0) begin failures++; $display("FAIL ovf_pre_clr got=%b exp=0", sbus.o_ovf); end
        sbus.i_clr = 1; tick(); sbus.i_clr = 0; sbus.i_en = 0; sbus.i_evt = '0;
        checks++; if (sbus.o_ovf !== '0) begin failures++; $display("FAIL ovf_clr_wins got=%b exp=0", sbus.o_ovf); end
        sbus.i_rd_sel = 3; tick();
        checks++; if (sbus.o_rd_data !== 4'd0) begin failures++; $display("FAIL ovf_clr_cnt got=%0d exp=0", sbus.o_rd_data); end
    endtask

    task automatic test_random();
        bus.i_clr = 1; tick(); bus.i_clr = 0;
        for (int i = 0; i < 400; i++) begin
            bus.i_en       = ($urandom_range(0, 7) != 0);
            bus.i_clr      = ($urandom_range(0, 49) == 0);
            bus.i_insn_vld = 1'($urandom);
            bus.i_evt      = NUM_EVT'($urandom);
            bus.i_instr    = ($urandom_range(0, 19) == 0) ? HALT : (32'($urandom) | 32'h100);
            bus.i_rd_sel   = SEL_W'($urandom_range(0, (1 << SEL_W) - 1));
            tick();
            checks++;
            if (bus.o_rd_data !== CNT_W'(m_rd) || bus.o_state !== 2'(m_st) ||
                bus.o_halted !== (m_st == 3) || bus.o_ovf !== m_ovf) begin
                failures++;
                $display("FAIL rand i=%0d rd=%0h/%0h st=%0d/%0d halted=%0b ovf=%0h/%0h (got/exp)",
                         i, bus.o_rd_data, m_rd, bus.o_state, m_st, bus.o_halted, bus.o_ovf, m_ovf);
            end
        end
        bus.i_clr = 0; bus.i_en = 0;
    endtask

    initial begin
        test_reset();
        test_count_basic();
        test_halt();
        test_pause_and_latency();
        test_async_reset();
        test_clr_halt();
        test_overflow();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout reached");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/perf_monitor.md
# perf_monitor

Synthesizable pipeline performance monitor for the RV32I pipelined cores (non-forwarding and forwarding variants). It counts cycles, valid (issued) instructions, bubbles, and a parametrised number of external event strobes. It also detects the program-end self-loop instruction and freezes all counters a fixed number of cycles later. It sits beside the core top, taps the core's instruction-valid flag, IF-stage instruction word and hazard strobes, and exposes a registered read port for the LSU or debug logic.

## Interface
Parameters:
- CNT_W, 32: width of every counter.
- NUM_EVT, 4: number of external event inputs (e.g. stall, flush, load-use, mispredict); range 1-16.
- HALT_INSN, 32'h0000006f: instruction word marking program end (jal x0, 0).
- HALT_HOLD, 4: cycles counted after halt detection before freeze; range 1-255.

Ports:
- i_clk  in  1  core clock; all state updates on rising edge.
- i_rstn  in  1  asynchronous, active-low reset.
- i_en  in  1  counting enable.
- i_clr  in  1  synchronous clear of counters, flags and FSM.
- i_insn_vld  in  1  core instruction-valid flag (0 = bubble/NOP).
- i_instr  in  32  IF-stage instruction word.
- i_evt  in  NUM_EVT  event strobes, one count per high cycle.
- i_rd_sel  in  $clog2(NUM_EVT+3)  read select: 0 cycles, 1 valid, 2 bubbles, 3+k event k.
- o_rd_data  out  CNT_W  registered counter value.
- o_ovf  out  NUM_EVT+3  sticky per-counter overflow flags, same index map as i_rd_sel.
- o_state  out  2  FSM state: 0 IDLE, 1 RUN, 2 DRAIN, 3 HALTED.
- o_halted  out  1  high in HALTED.

## Operation
- FSM:
  - IDLE → RUN when i_en=1.
  - RUN → DRAIN when i_instr==HALT_INSN; the hold counter loads HALT_HOLD-1.
  - DRAIN decrements the hold counter each cycle; at 0 → HALTED.
  - HALTED holds until i_clr.
  - The halt match is ignored in IDLE, DRAIN and HALTED.
- Counting is active when the state is RUN or DRAIN and i_en=1. In the same cycle:
  - cycles +1
  - valid +1 if i_insn_vld
  - bubbles +1 if !i_insn_vld
  - event k +1 if i_evt[k]
- The halt-match cycle itself is counted.
- i_en=0 in RUN/DRAIN pauses the counters only; FSM and hold countdown continue.
- Counters wrap modulo 2^CNT_W. On the wrap edge the matching o_ovf bit sets and stays set until i_clr or reset.
- i_clr has priority over every other event: all counters, o_ovf, and the hold counter go to 0, state → IDLE. Counting resumes the cycle after i_en is seen in IDLE.
- i_rd_sel ≥ NUM_EVT+3 returns 0.

## Timing
- Reset values (asynchronous): all counters 0, o_rd_data 0, o_ovf 0, o_state IDLE, o_halted 0, hold counter 0.
- Reset asserted mid-DRAIN or in HALTED returns to IDLE immediately; no partial-freeze state survives.
- Read latency: 1 cycle. o_rd_data reflects the counter value after the edge on which i_rd_sel was sampled; it does not include that edge's increment.
- Freeze latency: from the match edge, exactly HALT_HOLD further counted edges, then HALTED. The cycle counter total after halt = cycles up to and including the match + HALT_HOLD.
- i_clr and a halt match on the same edge: i_clr wins, state IDLE.
- Overflow and clear on the same edge: clear wins, flag stays 0.

## Configuration
- PERF_MON_SAT_EN defined: counters saturate at 2^CNT_W-1 instead of wrapping; o_ovf sets on the first increment attempted at saturation.
- PERF_MON_SAT_EN undefined: wrap-around behaviour as specified above.

## Test plan
- Reset, i_en=1, i_insn_vld pattern 1,1,0,1,0 for 5 cycles, then i_clr → before clear cycles=5, valid=3, bubbles=2; after clear all read 0, o_state=0.
- Run 10 cycles, then drive i_instr=32'h0000006f for one cycle, HALT_HOLD=4 → o_state=2 for 4 cycles, then o_halted=1. cycles=15 and stays 15 for 20 further cycles.
- CNT_W=4, i_evt[0] high for 17 cycles → event0=1, o_ovf[3]=1. With PERF_MON_SAT_EN: event0=15, o_ovf[3]=1.
- i_en toggles 1,0,0,1 over 4 cycles in RUN → cycles=2; i_rd_sel change reflected on o_rd_data exactly 1 cycle later.
- Assert i_rstn low mid-DRAIN → all outputs 0 and o_state=0 asynchronously, before the next clock edge.
- i_clr and halt match on the same edge → o_state=0, counters 0, no DRAIN entry.
